// File: rtl/video_pattern_gen.sv
// Test-pattern video timing generator: NTSC/PAL raster, optional scan doubling,
// four selectable patterns. Mode and pattern are latched only at the frame wrap.
module video_pattern_gen #(
  parameter int unsigned CW           = 8,
  parameter int unsigned HTOTAL       = 638,
  parameter int unsigned HBLANK_START = 529,
  parameter int unsigned HSYNC_START  = 544,
  parameter int unsigned HSYNC_END    = 590
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pal,
  input  logic          scandouble,
  input  logic [1:0]    pat_sel,
  output logic          ce_pix,
  output logic          HBlank,
  output logic          HSync,
  output logic          VBlank,
  output logic          VSync,
  output logic          frame_start,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_NOISE = 2'd2,
    PAT_CHECK = 2'd3
  } pat_t;

  localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
  localparam logic [9:0] H_BLANK = 10'(HBLANK_START);
  localparam logic [9:0] H_SYNC0 = 10'(HSYNC_START);
  localparam logic [9:0] H_SYNC1 = 10'(HSYNC_END);

  logic [9:0]  hc, vc;
  logic [7:0]  frame;
  logic [15:0] lfsr;
  logic        pal_l, sd_l;
  pat_t        pat_l;

  logic [9:0]  v_last, v_vbs, v_vss, v_vse;
  logic [9:0]  line;
  logic        wrap, sd_next, lfsr_fb, active;
  logic [2:0]  bar_c;
  logic [15:0] hsum, hc16, line16, hxl;
  logic [CW-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    v_last = 10'd261; v_vbs = 10'd240; v_vss = 10'd245; v_vse = 10'd248;
    case ({pal_l, sd_l})
      2'b01: begin v_last = 10'd523; v_vbs = 10'd480; v_vss = 10'd490; v_vse = 10'd496; end
      2'b10: begin v_last = 10'd311; v_vbs = 10'd300; v_vss = 10'd304; v_vse = 10'd308; end
      2'b11: begin v_last = 10'd623; v_vbs = 10'd601; v_vss = 10'd609; v_vse = 10'd617; end
      default: ;
    endcase
  end

  assign wrap    = ce_pix && (hc == H_LAST) && (vc == v_last);
  // ce_pix follows the mode that will be latched on this edge, so a frame that
  // switches into scan doubling starts with ce_pix already constant.
  assign sd_next = wrap ? scandouble : sd_l;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign line    = sd_l ? {1'b0, vc[9:1]} : vc;
  assign active  = (hc < H_BLANK) && (vc < v_vbs);

  assign bar_c  = 3'd7 - hc[8:6];
  assign hc16   = {6'b0, hc};
  assign line16 = {6'b0, line};
  assign hsum   = hc16 + {8'b0, frame};
  assign hxl    = hc16 ^ line16;

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (pat_l)
      PAT_BARS: begin
        if (hc[9]) begin
          pix_r = '1; pix_g = '1; pix_b = '1;
        end else begin
          pix_r = {CW{bar_c[1]}};
          pix_g = {CW{bar_c[2]}};
          pix_b = {CW{bar_c[0]}};
        end
      end
      PAT_GRAD: begin
        pix_r = hsum[CW-1:0];
        pix_g = line16[CW-1:0];
        pix_b = hxl[CW-1:0];
      end
      PAT_NOISE: begin
        pix_r = lfsr[CW-1:0];
        pix_g = lfsr[CW-1:0];
        pix_b = lfsr[CW-1:0];
      end
      PAT_CHECK: begin
        pix_r = {CW{hsum[4] ^ line[4]}};
        pix_g = {CW{hsum[4] ^ line[4]}};
        pix_b = {CW{hsum[4] ^ line[4]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      frame       <= '0;
      lfsr        <= 16'hACE1;
      pal_l       <= 1'b0;
      sd_l        <= 1'b0;
      pat_l       <= PAT_BARS;
      ce_pix      <= 1'b0;
      HBlank      <= 1'b0;
      HSync       <= 1'b0;
      VBlank      <= 1'b0;
      VSync       <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      ce_pix      <= sd_next ? 1'b1 : ~ce_pix;
      frame_start <= wrap;
      HBlank      <= (hc >= H_BLANK);
      HSync       <= (hc >= H_SYNC0) && (hc < H_SYNC1);
      if (hc == H_SYNC0) begin
        VBlank <= (vc >= v_vbs);
        VSync  <= (vc >= v_vss) && (vc < v_vse);
      end
      r <= active ? pix_r : '0;
      g <= active ? pix_g : '0;
      b <= active ? pix_b : '0;
      if (ce_pix) begin
        lfsr <= {lfsr[14:0], lfsr_fb};
        if (hc == H_LAST) begin
          hc <= '0;
          if (vc == v_last) begin
            vc    <= '0;
            frame <= frame + 8'd1;
            pal_l <= pal;
            sd_l  <= scandouble;
            pat_l <= pat_t'(pat_sel);
          end else begin
            vc <= vc + 10'd1;
          end
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

endmodule
